// File: rtl/caf_sweep_pkg.sv
// Shared definitions for the CAF frequency-sweep controller.
package caf_sweep_pkg;

    // Sweep controller states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_REPLAY  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_COMPARE = 3'd5,
        ST_DONE    = 3'd6
    } caf_state_e;

    // Width of the signed per-bin frequency: base magnitude, bin*incr growth and a sign bit.
    function automatic int freq_width(input int phase_bits, input int bin_bits);
        return phase_bits + bin_bits + 1;
    endfunction

endpackage

// File: rtl/caf_sweep_if.sv
// Bus bundle between the sweep controller and its environment
// (sample source, single-bin slice engine, result sink).
//
// Handshake rule for every channel here: a beat transfers on a rising clk edge
// where valid and ready are both 1; once valid is raised, the producer holds
// valid and its data stable until that edge.
interface caf_sweep_if #(
    parameter int phase_bits          = 10,
    parameter int xi_bits             = 12,
    parameter int xq_bits             = 12,
    parameter int yi_bits             = 12,
    parameter int yq_bits             = 12,
    parameter int length_counter_bits = 3,
    parameter int out_max_bits        = 5,
    parameter int bin_bits            = 3
);
    import caf_sweep_pkg::*;

    // sweep control
    logic                           start;
    logic [phase_bits-1:0]          freq_base;
    logic                           base_neg;
    logic [phase_bits-1:0]          freq_incr;
    logic                           busy;
    // sample capture stream
    logic                           m_axis_tvalid;
    logic [xi_bits-1:0]             xi;
    logic [xq_bits-1:0]             xq;
    logic [yi_bits-1:0]             yi;
    logic [yq_bits-1:0]             yq;
    logic                           s_axis_tready;
    // slice engine: frequency load and replay stream
    logic                           slice_freq_valid;
    logic [phase_bits-1:0]          slice_freq_step;
    logic                           slice_neg_shift;
    logic                           slice_tvalid;
    logic [xi_bits-1:0]             slice_xi;
    logic [xq_bits-1:0]             slice_xq;
    logic [yi_bits-1:0]             slice_yi;
    logic [yq_bits-1:0]             slice_yq;
    logic                           slice_tready;
    // slice engine: per-bin peak
    logic                           slice_result_valid;
    logic [out_max_bits-1:0]        slice_out_max;
    logic [length_counter_bits-1:0] slice_index;
    logic                           slice_result_ready;
    // sweep result
    logic                           s_axis_tvalid;
    logic                           m_axis_tready;
    logic [out_max_bits-1:0]        peak_max;
    logic [length_counter_bits-1:0] peak_index;
    logic [bin_bits-1:0]            peak_bin;
    // controller state, for observation only
    caf_state_e                     dbg_state;

    modport slave (
        input  start, freq_base, base_neg, freq_incr,
        input  m_axis_tvalid, xi, xq, yi, yq,
        input  slice_tready, slice_result_valid, slice_out_max, slice_index,
        input  m_axis_tready,
        output busy, s_axis_tready,
        output slice_freq_valid, slice_freq_step, slice_neg_shift,
        output slice_tvalid, slice_xi, slice_xq, slice_yi, slice_yq,
        output slice_result_ready,
        output s_axis_tvalid, peak_max, peak_index, peak_bin, dbg_state
    );

    modport master (
        output start, freq_base, base_neg, freq_incr,
        output m_axis_tvalid, xi, xq, yi, yq,
        output slice_tready, slice_result_valid, slice_out_max, slice_index,
        output m_axis_tready,
        input  busy, s_axis_tready,
        input  slice_freq_valid, slice_freq_step, slice_neg_shift,
        input  slice_tvalid, slice_xi, slice_xq, slice_yi, slice_yq,
        input  slice_result_ready,
        input  s_axis_tvalid, peak_max, peak_index, peak_bin, dbg_state
    );

endinterface

// File: rtl/caf_sample_buffer.sv
// Block buffer for one captured block of x/y sample pairs.
// Contents are deliberately not reset: a fresh capture overwrites every entry.
module caf_sample_buffer #(
    parameter int width     = 48,
    parameter int depth     = 5,
    parameter int addr_bits = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [addr_bits-1:0] wr_addr,
    input  logic [width-1:0]     wr_data,
    input  logic [addr_bits-1:0] rd_addr,
    output logic [width-1:0]     rd_data
);

    logic [width-1:0] mem [depth];

    // Write port: one entry per accepted capture beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read; addresses past the block read as zero.
    always_comb begin
        rd_data = (32'(rd_addr) < depth) ? mem[rd_addr] : '0;
    end

endmodule

// File: rtl/caf_sweep.sv
// Multi-bin CAF sweep: capture one block, replay it once per frequency bin
// into an external slice engine, and track the global peak across bins.
module caf_sweep
    import caf_sweep_pkg::*;
#(
    parameter int phase_bits          = 10,
    parameter int xi_bits             = 12,
    parameter int xq_bits             = 12,
    parameter int yi_bits             = 12,
    parameter int yq_bits             = 12,
    parameter int length              = 5,
    parameter int length_counter_bits = 3,
    parameter int out_max_bits        = 5,
    parameter int num_bins            = 8,
    parameter int bin_bits            = 3
) (
    input  logic       clk,
    input  logic       reset,
    caf_sweep_if.slave bus
);

    localparam int FW = freq_width(phase_bits, bin_bits);
    localparam int SW = xi_bits + xq_bits + yi_bits + yq_bits;
    localparam logic [length_counter_bits-1:0] LAST_CNT = length_counter_bits'(length - 1);
    localparam logic [bin_bits-1:0]            LAST_BIN = bin_bits'(num_bins - 1);

    caf_state_e                     state_q;
    logic [length_counter_bits-1:0] cnt_q;
    logic [bin_bits-1:0]            bin_q;
    logic [phase_bits-1:0]          base_q, incr_q;
    logic                           neg_q;
    logic [out_max_bits-1:0]        res_max_q, peak_max_q;
    logic [length_counter_bits-1:0] res_index_q, peak_index_q;
    logic [bin_bits-1:0]            peak_bin_q;
    logic                           tready_q, freq_valid_q, neg_shift_q, tvalid_q;
    logic                           result_ready_q, out_valid_q, busy_q;
    logic [phase_bits-1:0]          step_q;

    logic                           wr_en;
    logic [SW-1:0]                  wr_data, rd_data;
    logic [bin_bits-1:0]            load_bin;
    logic signed [FW-1:0]           f_next;
    logic [phase_bits-1:0]          f_mag;
    logic [bin_bits-1:0]            unused_f_mid;

    // Signed bin frequency: +/-base plus bin*incr, wide enough never to overflow.
    function automatic logic signed [FW-1:0] bin_freq(
        input logic [phase_bits-1:0] base,
        input logic                  neg,
        input logic [phase_bits-1:0] incr,
        input logic [bin_bits-1:0]   b
    );
        logic signed [FW-1:0] base_s;
        logic signed [FW-1:0] prod_s;
        base_s = $signed(FW'(base));
        if (neg) begin
            base_s = -base_s;
        end
        prod_s = $signed(FW'(b) * FW'(incr));
        return base_s + prod_s;
    endfunction

    assign wr_en   = tready_q & bus.m_axis_tvalid;
    assign wr_data = {bus.xi, bus.xq, bus.yi, bus.yq};

    caf_sample_buffer #(
        .width     (SW),
        .depth     (length),
        .addr_bits (length_counter_bits)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cnt_q),
        .wr_data (wr_data),
        .rd_addr (cnt_q),
        .rd_data (rd_data)
    );

    // Frequency for the bin about to be loaded (bin 0 after capture, bin+1 after compare).
    // Only the low phase_bits of |f| go out, so the magnitude is negated on those bits alone.
    always_comb begin
        load_bin     = (state_q == ST_COMPARE) ? bin_q + 1'b1 : '0;
        f_next       = bin_freq(base_q, neg_q, incr_q, load_bin);
        f_mag        = f_next[FW-1] ? (~f_next[phase_bits-1:0] + 1'b1) : f_next[phase_bits-1:0];
        unused_f_mid = f_next[FW-2:phase_bits];
    end

    // Sweep FSM; every output flag is registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bin_q          <= '0;
            base_q         <= '0;
            incr_q         <= '0;
            neg_q          <= 1'b0;
            res_max_q      <= '0;
            res_index_q    <= '0;
            peak_max_q     <= '0;
            peak_index_q   <= '0;
            peak_bin_q     <= '0;
            tready_q       <= 1'b0;
            freq_valid_q   <= 1'b0;
            step_q         <= '0;
            neg_shift_q    <= 1'b0;
            tvalid_q       <= 1'b0;
            result_ready_q <= 1'b0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        base_q       <= bus.freq_base;
                        neg_q        <= bus.base_neg;
                        incr_q       <= bus.freq_incr;
                        peak_max_q   <= '0;
                        peak_index_q <= '0;
                        peak_bin_q   <= '0;
                        cnt_q        <= '0;
                        bin_q        <= '0;
                        tready_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (wr_en) begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q        <= '0;
                            tready_q     <= 1'b0;
                            step_q       <= f_mag;
                            neg_shift_q  <= f_next[FW-1];
                            freq_valid_q <= 1'b1;
                            state_q      <= ST_LOAD;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    tvalid_q <= 1'b1;
                    state_q  <= ST_REPLAY;
                end
                ST_REPLAY: begin
                    if (bus.slice_tready) begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q          <= '0;
                            tvalid_q       <= 1'b0;
                            result_ready_q <= 1'b1;
                            state_q        <= ST_WAIT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.slice_result_valid) begin
                        res_max_q      <= bus.slice_out_max;
                        res_index_q    <= bus.slice_index;
                        result_ready_q <= 1'b0;
                        state_q        <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    // Strictly greater: on ties the earlier bin keeps the peak.
                    if (bin_q == '0 || res_max_q > peak_max_q) begin
                        peak_max_q   <= res_max_q;
                        peak_index_q <= res_index_q;
                        peak_bin_q   <= bin_q;
                    end
                    if (bin_q == LAST_BIN) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        bin_q        <= load_bin;
                        step_q       <= f_mag;
                        neg_shift_q  <= f_next[FW-1];
                        freq_valid_q <= 1'b1;
                        state_q      <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (bus.m_axis_tready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_axis_tready      = tready_q;
    assign bus.slice_freq_valid   = freq_valid_q;
    assign bus.slice_freq_step    = step_q;
    assign bus.slice_neg_shift    = neg_shift_q;
    assign bus.slice_tvalid       = tvalid_q;
    assign bus.slice_xi           = tvalid_q ? rd_data[SW-1 -: xi_bits] : '0;
    assign bus.slice_xq           = tvalid_q ? rd_data[yi_bits+yq_bits+xq_bits-1 -: xq_bits] : '0;
    assign bus.slice_yi           = tvalid_q ? rd_data[yq_bits+yi_bits-1 -: yi_bits] : '0;
    assign bus.slice_yq           = tvalid_q ? rd_data[yq_bits-1:0] : '0;
    assign bus.slice_result_ready = result_ready_q;
    assign bus.s_axis_tvalid      = out_valid_q;
    assign bus.peak_max           = peak_max_q;
    assign bus.peak_index         = peak_index_q;
    assign bus.peak_bin           = peak_bin_q;
    assign bus.busy               = busy_q;
    assign bus.dbg_state          = state_q;

endmodule

// File: tb/tb_caf_sweep.sv
// Directed bench for caf_sweep with a 4-bin sweep and a behavioural slice engine.
module tb_caf_sweep;

    localparam int PB  = 10;
    localparam int LEN = 5;
    localparam int LCB = 3;
    localparam int OMB = 5;
    localparam int NB  = 4;
    localparam int BB  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    caf_sweep_if #(.phase_bits(PB), .length_counter_bits(LCB), .out_max_bits(OMB), .bin_bits(BB)) bus ();

    caf_sweep #(
        .phase_bits(PB), .length(LEN), .length_counter_bits(LCB),
        .out_max_bits(OMB), .num_bins(NB), .bin_bits(BB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // engine responses and captured samples
    logic [OMB-1:0] eng_max [NB];
    logic [LCB-1:0] eng_idx [NB];
    logic [11:0]    cap_xi [LEN], cap_xq [LEN], cap_yi [LEN], cap_yq [LEN];

    // observations from the last sweep
    logic [PB-1:0]  obs_step [NB];
    logic           obs_neg [NB];
    int             nload, rep_err, rep_total, stable_err, lat, done_cycles;
    logic [OMB-1:0] res_max;
    logic [LCB-1:0] res_idx;
    logic [BB-1:0]  res_bin;
    bit             finished;

    task automatic drive_idle();
        bus.start = 0; bus.freq_base = '0; bus.base_neg = 0; bus.freq_incr = '0;
        bus.m_axis_tvalid = 0; bus.xi = '0; bus.xq = '0; bus.yi = '0; bus.yq = '0;
        bus.slice_tready = 0; bus.slice_result_valid = 0; bus.slice_out_max = '0;
        bus.slice_index = '0; bus.m_axis_tready = 0;
    endtask

    // Runs one sweep as sample source, slice engine and result sink.
    // abort_bin >= 0 asserts reset mid-replay of that bin and returns at once.
    task automatic run_sweep(input logic [PB-1:0] fb, input logic bn, input logic [PB-1:0] fi,
                             input bit gaps, input int done_hold, input bit poke_start,
                             input int abort_bin);
        int sent, rep_cnt, cyc, first_beat, hold;
        bit seen_done, acked;
        for (int i = 0; i < LEN; i++) begin
            cap_xi[i] = 12'($urandom_range(0, 4095)); cap_xq[i] = 12'($urandom_range(0, 4095));
            cap_yi[i] = 12'($urandom_range(0, 4095)); cap_yq[i] = 12'($urandom_range(0, 4095));
        end
        nload = 0; rep_err = 0; rep_total = 0; stable_err = 0; lat = -1; done_cycles = 0;
        finished = 0; sent = 0; rep_cnt = 0; cyc = 0; first_beat = -1; hold = 0;
        seen_done = 0; acked = 0;
        @(negedge clk);
        bus.start = 1; bus.freq_base = fb; bus.base_neg = bn; bus.freq_incr = fi;
        while (cyc < 3000 && !finished) begin
            @(negedge clk);
            bus.start = 0; bus.m_axis_tvalid = 0; bus.slice_tready = 0;
            bus.slice_result_valid = 0; bus.m_axis_tready = 0;
            if (acked) begin
                finished = 1;
            end else begin
                if (bus.slice_freq_valid) begin
                    if (nload < NB) begin
                        obs_step[nload] = bus.slice_freq_step;
                        obs_neg[nload]  = bus.slice_neg_shift;
                    end
                    nload++;
                    rep_cnt = 0;
                end
                if (bus.s_axis_tready && sent < LEN) begin
                    if (!gaps || $urandom_range(0, 2) != 0) begin
                        bus.m_axis_tvalid = 1;
                        bus.xi = cap_xi[sent]; bus.xq = cap_xq[sent];
                        bus.yi = cap_yi[sent]; bus.yq = cap_yq[sent];
                        if (first_beat < 0) first_beat = cyc;
                        sent++;
                    end
                    if (poke_start && sent == 2) bus.start = 1;
                end
                if (bus.slice_tvalid) begin
                    if (rep_cnt >= LEN) rep_err++;
                    else if ({bus.slice_xi, bus.slice_xq, bus.slice_yi, bus.slice_yq} !==
                             {cap_xi[rep_cnt], cap_xq[rep_cnt], cap_yi[rep_cnt], cap_yq[rep_cnt]})
                        rep_err++;
                    if (abort_bin >= 0 && nload == abort_bin + 1 && rep_cnt == 2) begin
                        reset = 1;
                        return;
                    end
                    if (!gaps || $urandom_range(0, 1) != 0) begin
                        bus.slice_tready = 1;
                        rep_cnt++;
                        rep_total++;
                    end
                end
                if (bus.slice_result_ready && nload >= 1 && nload <= NB) begin
                    if (!gaps || $urandom_range(0, 2) == 0) begin
                        bus.slice_result_valid = 1;
                        bus.slice_out_max = eng_max[nload-1];
                        bus.slice_index   = eng_idx[nload-1];
                    end
                end
                if (bus.s_axis_tvalid) begin
                    if (!seen_done) begin
                        res_max = bus.peak_max; res_idx = bus.peak_index; res_bin = bus.peak_bin;
                        lat = cyc - first_beat;
                        seen_done = 1;
                    end else if ({bus.peak_max, bus.peak_index, bus.peak_bin} !== {res_max, res_idx, res_bin}) begin
                        stable_err++;
                    end
                    done_cycles++;
                    if (hold >= done_hold) begin
                        bus.m_axis_tready = 1;
                        acked = 1;
                        if (poke_start) bus.start = 1;
                    end else begin
                        hold++;
                    end
                end
                cyc++;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL sweep_timeout: got no result handshake within %0d cycles, required completion", cyc);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.s_axis_tready, bus.slice_freq_valid, bus.slice_freq_step, bus.slice_neg_shift,
             bus.slice_tvalid, bus.slice_xi, bus.slice_xq, bus.slice_yi, bus.slice_yq,
             bus.slice_result_ready, bus.s_axis_tvalid, bus.peak_max, bus.peak_index,
             bus.peak_bin, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero output under reset, required all zero");
        end
        reset = 0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b tready=%b, required 0 0", bus.busy, bus.s_axis_tready);
        end
    endtask

    task automatic test_basic();
        logic [PB-1:0] exp_step [NB];
        exp_step = '{10'd10, 10'd13, 10'd16, 10'd19};
        eng_max = '{5'd5, 5'd9, 5'd7, 5'd2};
        eng_idx = '{3'd1, 3'd3, 3'd0, 3'd4};
        run_sweep(10'd10, 1'b0, 10'd3, 0, 0, 0, -1);
        checks++;
        if (nload !== NB) begin
            errors++; $display("FAIL basic_loads: got %0d, required %0d", nload, NB);
        end
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (obs_step[b] !== exp_step[b] || obs_neg[b] !== 1'b0) begin
                errors++;
                $display("FAIL basic_freq bin%0d: got step=%0d neg=%b, required step=%0d neg=0",
                         b, obs_step[b], obs_neg[b], exp_step[b]);
            end
        end
        checks++;
        if (rep_err != 0 || rep_total != NB * LEN) begin
            errors++; $display("FAIL basic_replay: got %0d bad of %0d beats, required 0 bad of %0d", rep_err, rep_total, NB * LEN);
        end
        checks++;
        if ({res_max, res_idx, res_bin} !== {5'd9, 3'd3, 2'd1}) begin
            errors++; $display("FAIL basic_peak: got max=%0d idx=%0d bin=%0d, required 9 3 1", res_max, res_idx, res_bin);
        end
        checks++;
        if (lat != LEN + NB * (LEN + 3)) begin
            errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, LEN + NB * (LEN + 3));
        end
        checks++;
        if (bus.s_axis_tvalid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_release: got tvalid=%b busy=%b, required 0 0", bus.s_axis_tvalid, bus.busy);
        end
    endtask

    task automatic test_sign_crossing();
        logic [PB-1:0] exp_step [NB];
        logic          exp_neg [NB];
        exp_step = '{10'd5, 10'd3, 10'd1, 10'd1};
        exp_neg  = '{1'b1, 1'b1, 1'b1, 1'b0};
        eng_max = '{5'd1, 5'd1, 5'd1, 5'd1};
        eng_idx = '{3'd0, 3'd0, 3'd0, 3'd0};
        run_sweep(10'd5, 1'b1, 10'd2, 0, 0, 0, -1);
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (obs_step[b] !== exp_step[b] || obs_neg[b] !== exp_neg[b]) begin
                errors++;
                $display("FAIL sign_freq bin%0d: got (%0d,%b), required (%0d,%b)",
                         b, obs_step[b], obs_neg[b], exp_step[b], exp_neg[b]);
            end
        end
    endtask

    task automatic test_ties();
        eng_max = '{5'd6, 5'd6, 5'd6, 5'd6};
        eng_idx = '{3'd4, 3'd1, 3'd2, 3'd3};
        run_sweep(10'd7, 1'b0, 10'd1, 0, 0, 0, -1);
        checks++;
        if ({res_max, res_idx, res_bin} !== {5'd6, 3'd4, 2'd0}) begin
            errors++; $display("FAIL tie_peak: got max=%0d idx=%0d bin=%0d, required 6 4 0", res_max, res_idx, res_bin);
        end
        eng_max = '{5'd0, 5'd0, 5'd0, 5'd0};
        eng_idx = '{3'd2, 3'd4, 3'd1, 3'd3};
        run_sweep(10'd7, 1'b0, 10'd1, 0, 0, 0, -1);
        checks++;
        if ({res_max, res_idx, res_bin} !== {5'd0, 3'd2, 2'd0}) begin
            errors++; $display("FAIL zero_peak: got max=%0d idx=%0d bin=%0d, required 0 2 0", res_max, res_idx, res_bin);
        end
        eng_max = '{5'd1, 5'd2, 5'd3, 5'd31};
        eng_idx = '{3'd0, 3'd1, 3'd2, 3'd4};
        run_sweep(10'd7, 1'b0, 10'd1, 0, 0, 0, -1);
        checks++;
        if ({res_max, res_idx, res_bin} !== {5'd31, 3'd4, 2'd3}) begin
            errors++; $display("FAIL last_bin_peak: got max=%0d idx=%0d bin=%0d, required 31 4 3", res_max, res_idx, res_bin);
        end
    endtask

    task automatic test_backpressure();
        eng_max = '{5'd3, 5'd8, 5'd12, 5'd12};
        eng_idx = '{3'd1, 3'd2, 3'd3, 3'd0};
        run_sweep(10'd100, 1'b0, 10'd50, 1, 10, 0, -1);
        checks++;
        if (rep_err != 0 || rep_total != NB * LEN) begin
            errors++; $display("FAIL bp_replay: got %0d bad of %0d beats, required 0 bad of %0d", rep_err, rep_total, NB * LEN);
        end
        checks++;
        if (stable_err != 0 || done_cycles != 11) begin
            errors++; $display("FAIL bp_hold: got %0d unstable of %0d valid cycles, required 0 of 11", stable_err, done_cycles);
        end
        checks++;
        if ({res_max, res_idx, res_bin} !== {5'd12, 3'd3, 2'd2}) begin
            errors++; $display("FAIL bp_peak: got max=%0d idx=%0d bin=%0d, required 12 3 2", res_max, res_idx, res_bin);
        end
    endtask

    task automatic test_reset_mid_replay();
        eng_max = '{5'd1, 5'd2, 5'd3, 5'd4};
        eng_idx = '{3'd0, 3'd0, 3'd0, 3'd0};
        run_sweep(10'd20, 1'b0, 10'd5, 0, 0, 0, 2);
        @(negedge clk);
        checks++;
        if ({bus.s_axis_tready, bus.slice_freq_valid, bus.slice_freq_step, bus.slice_neg_shift,
             bus.slice_tvalid, bus.slice_xi, bus.slice_xq, bus.slice_yi, bus.slice_yq,
             bus.slice_result_ready, bus.s_axis_tvalid, bus.peak_max, bus.peak_index,
             bus.peak_bin, bus.busy} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got nonzero output after reset (busy=%b), required all zero", bus.busy);
        end
        reset = 0;
        eng_max = '{5'd4, 5'd2, 5'd17, 5'd9};
        eng_idx = '{3'd1, 3'd2, 3'd4, 3'd3};
        run_sweep(10'd20, 1'b0, 10'd5, 0, 0, 0, -1);
        checks++;
        if ({res_max, res_idx, res_bin} !== {5'd17, 3'd4, 2'd2} || obs_step[3] !== 10'd35) begin
            errors++;
            $display("FAIL midreset_rerun: got max=%0d idx=%0d bin=%0d step3=%0d, required 17 4 2 35",
                     res_max, res_idx, res_bin, obs_step[3]);
        end
    endtask

    task automatic test_start_ignored();
        int extra;
        eng_max = '{5'd2, 5'd5, 5'd5, 5'd1};
        eng_idx = '{3'd0, 3'd2, 3'd3, 3'd1};
        run_sweep(10'd1, 1'b0, 10'd1, 0, 0, 1, -1);
        checks++;
        if (nload !== NB || {res_max, res_idx, res_bin} !== {5'd5, 3'd2, 2'd1}) begin
            errors++;
            $display("FAIL start_sweep: got loads=%0d max=%0d idx=%0d bin=%0d, required 4 5 2 1",
                     nload, res_max, res_idx, res_bin);
        end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.s_axis_tready !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL start_no_resweep: got %0d busy cycles after result, required 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_crossing();
        test_ties();
        test_backpressure();
        test_reset_mid_replay();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/caf_sweep.md
Name: caf_sweep

Overview:
- Multi-bin cross-ambiguity-function sweep controller and peak tracker.
- Captures one block of `length` x/y complex sample pairs into internal buffers.
- For each of `num_bins` frequency bins, replays the buffered block into an external single-bin slice engine (frequency shift plus cross-correlation) and collects that engine's per-bin peak.
- Reports the global peak as magnitude, time index and frequency bin. This lifts a single-frequency slice to a full frequency sweep.

Parameters:
phase_bits, 10, width of frequency step magnitude
xi_bits, 12, reference I width
xq_bits, 12, reference Q width
yi_bits, 12, received I width
yq_bits, 12, received Q width
length, 5, samples per block (buffer depth)
length_counter_bits, 3, width of sample counters and index
out_max_bits, 5, width of per-bin peak magnitude
num_bins, 8, frequency bins per sweep (>=1)
bin_bits, 3, width of bin counter, ceil(log2(num_bins)) (min 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  sweep request pulse
freq_base  in  phase_bits  bin-0 step magnitude
base_neg  in  1  bin-0 sign (1 = negative)
freq_incr  in  phase_bits  unsigned step between bins
m_axis_tvalid  in  1  input sample valid
xi  in  xi_bits  reference I
xq  in  xq_bits  reference Q
yi  in  yi_bits  received I
yq  in  yq_bits  received Q
s_axis_tready  out  1  capture ready
slice_freq_valid  out  1  one-cycle bin load pulse
slice_freq_step  out  phase_bits  bin step magnitude
slice_neg_shift  out  1  bin sign
slice_tvalid  out  1  replay sample valid
slice_xi  out  xi_bits  replayed xi
slice_xq  out  xq_bits  replayed xq
slice_yi  out  yi_bits  replayed yi
slice_yq  out  yq_bits  replayed yq
slice_tready  in  1  engine accepts replay sample
slice_result_valid  in  1  engine peak valid
slice_out_max  in  out_max_bits  engine peak magnitude
slice_index  in  length_counter_bits  engine peak index
slice_result_ready  out  1  result accepted
s_axis_tvalid  out  1  sweep result valid
m_axis_tready  in  1  downstream accepts result
peak_max  out  out_max_bits  global peak magnitude
peak_index  out  length_counter_bits  time index of global peak
peak_bin  out  bin_bits  bin of global peak
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-high on reset.
  - Reset forces state IDLE, clears all counters, and sets every output to 0.
  - Reset applied mid-sweep aborts the sweep with no result. Buffer contents are not cleared.
- States: IDLE, CAPTURE, LOAD, REPLAY, WAIT, COMPARE, DONE.
- IDLE:
  - start=1 latches freq_base, base_neg and freq_incr, clears the peak registers, and moves to CAPTURE.
  - start is ignored in every other state.
- CAPTURE:
  - s_axis_tready=1.
  - Each m_axis_tvalid&s_axis_tready beat writes buffer[cnt] and increments cnt.
  - After beat length-1, cnt resets and the state moves to LOAD.
- LOAD:
  - Computes signed f = (base_neg ? -freq_base : freq_base) + bin*freq_incr in phase_bits+bin_bits+1 bits.
  - slice_freq_step = |f| truncated to the low phase_bits. slice_neg_shift = (f<0).
  - slice_freq_valid pulses for exactly one cycle. Step and sign hold stable until the next LOAD.
  - Next state is REPLAY.
- REPLAY:
  - slice_tvalid=1 with the buffer[cnt] fields.
  - Data holds while slice_tready=0.
  - cnt advances on each accepted beat. After beat length-1, the state moves to WAIT.
- WAIT:
  - slice_result_ready=1.
  - On slice_result_valid, registers out_max/index and moves to COMPARE.
- COMPARE (one cycle):
  - If bin==0 or slice_out_max > peak_max (strictly greater), update peak_max, peak_index and peak_bin. Ties keep the earlier bin.
  - If bin==num_bins-1, go to DONE. Otherwise increment bin and go to LOAD.
- DONE:
  - s_axis_tvalid=1 with peak fields held stable until m_axis_tready=1.
  - On that handshake, go to IDLE and drop s_axis_tvalid.
  - A start pulse in the same cycle as the handshake is ignored.
- Valid-only signals are 0 outside their own states.
- Latency: the minimum sweep with ready always high is length + num_bins*(length+3) cycles from the first capture beat to s_axis_tvalid, plus the engine's result latency for each bin.

Decomposition:
- Shared package:
  - state encoding
  - the signed frequency width constant (phase_bits+bin_bits+1)
- Sub-module caf_sample_buffer:
  - length-deep register file
  - write port plus independent read address, combinational read
- The FSM and frequency arithmetic stay in caf_sweep.

Test Plan:
- Basic sweep: num_bins=4, freq_base=10, base_neg=0, freq_incr=3, engine returning out_max 5,9,7,2 with index 1,3,0,4 -> slice_freq_step 10,13,16,19; result peak_max=9, peak_index=3, peak_bin=1.
- Sign crossing: freq_base=5, base_neg=1, freq_incr=2, 4 bins -> pairs (5,1),(3,1),(1,1),(1,0).
- Tie: out_max 6,6,6,6 -> peak_bin=0. All-zero out_max -> peak_max=0, peak_bin=0.
- Backpressure: random gaps on m_axis_tvalid and slice_tready, m_axis_tready low for 10 cycles in DONE -> replayed sample sequence equals the captured sequence for every bin, and result fields stay stable while s_axis_tvalid is high.
- Reset mid-REPLAY of bin 2 -> next cycle all outputs 0, busy=0. A fresh start then completes correctly.
- start pulsed during CAPTURE and during DONE -> no state change and no extra sweep.
